// File: rtl/fir_out_decimator.sv
// FIR output conditioner: warm-up discard, decimation, scale/round/saturate, show-ahead FIFO.
// Optional `FIR_OUT_ROUND_EN selects round-half-up scaling; truncation toward -inf otherwise.
module fir_out_decimator #(
    parameter int IN_W   = 32,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 15,
    parameter int DECIM  = 4,
    parameter int WARMUP = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [IN_W-1:0]            din,
    input  logic                       din_en,
    output logic [OUT_W-1:0]           m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       sat_flag,
    output logic                       ovf_flag,
    input  logic                       clr_flags
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int PCW = (DECIM > 1) ? $clog2(DECIM) : 1;

`ifdef FIR_OUT_ROUND_EN
    localparam logic signed [IN_W:0] BIAS = (IN_W+1)'(1) << (SHIFT - 1);
`else
    localparam logic signed [IN_W:0] BIAS = '0;
`endif

    localparam logic signed [IN_W:0] MAXV = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MINV = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic {WARM, RUN} state_t;

    state_t         state, state_nxt;
    logic [WCW-1:0] wcnt, wcnt_nxt;
    logic [PCW-1:0] phase, phase_nxt;
    logic           keep;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= (WARMUP == 0) ? RUN : WARM;
            wcnt  <= '0;
            phase <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            phase <= phase_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        phase_nxt = phase;
        keep      = 1'b0;
        case (state)
            WARM: begin
                if (din_en) begin
                    if (int'(wcnt) == WARMUP - 1) state_nxt = RUN;
                    else                          wcnt_nxt  = wcnt + WCW'(1);
                end
            end
            RUN: begin
                if (din_en) begin
                    keep      = (phase == '0);
                    phase_nxt = (int'(phase) == DECIM - 1) ? '0 : phase + PCW'(1);
                end
            end
            default: state_nxt = WARM;
        endcase
    end

    // Stage 1: extend by one bit so the rounding bias cannot wrap.
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] s1_r;
    logic                 s1_vld;

    assign sum = $signed({din[IN_W-1], din}) + BIAS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_r   <= '0;
        end else begin
            s1_vld <= keep;
            s1_r   <= sum >>> SHIFT;
        end
    end

    // Stage 2: clamp feeds the FIFO write port directly.
    logic [OUT_W-1:0] sat_val;
    logic             clamped;

    always_comb begin
        sat_val = s1_r[OUT_W-1:0];
        clamped = 1'b0;
        if (s1_r > MAXV) begin
            sat_val = MAXV[OUT_W-1:0];
            clamped = 1'b1;
        end else if (s1_r < MINV) begin
            sat_val = MINV[OUT_W-1:0];
            clamped = 1'b1;
        end
    end

    logic [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr, rd_nxt;
    logic [LW-1:0]    level_nxt;
    logic             full, pop, wr_ok;

    assign full   = (level == LW'(DEPTH));
    assign pop    = m_valid & m_ready;
    assign wr_ok  = s1_vld & (~full | pop);
    assign rd_nxt = rd_ptr + AW'(1);

    always_comb begin
        level_nxt = level;
        case ({wr_ok, pop})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= sat_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            level   <= level_nxt;
            m_valid <= (level_nxt != '0);
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_nxt;
            // Registered head: the next entry, or the incoming write when it becomes the head.
            if (pop) begin
                if (level == LW'(1)) begin
                    if (wr_ok) m_data <= sat_val;
                end else begin
                    m_data <= mem[rd_nxt];
                end
            end else if (level == '0 && wr_ok) begin
                m_data <= sat_val;
            end
            sat_flag <= (wr_ok & clamped) | (sat_flag & ~clr_flags);
            ovf_flag <= (s1_vld & ~wr_ok) | (ovf_flag & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_fir_out_decimator.sv
// Bench for fir_out_decimator: directed scenarios plus random traffic against a queue-based model.
module tb_fir_out_decimator;

    localparam int IN_W = 32, OUT_W = 16, SHIFT = 15, DECIM = 4, WARMUP = 8, DEPTH = 8;
`ifdef FIR_OUT_ROUND_EN
    localparam longint BIAS = 64'sd1 <<< (SHIFT - 1);
    localparam int R_POS = 2, R_NEG = -1;
`else
    localparam longint BIAS = 0;
    localparam int R_POS = 1, R_NEG = -2;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [IN_W-1:0]   din = '0;
    logic              din_en = 1'b0;
    logic [OUT_W-1:0]  m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [3:0]        level;
    logic              sat_flag, ovf_flag;
    logic              clr_flags = 1'b0;

    int total = 0;
    int bad   = 0;

    fir_out_decimator dut (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
        .sat_flag(sat_flag), .ovf_flag(ovf_flag), .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    // Reference model: sample index since reset decides keep; pending holds the value in flight.
    int mq[$];
    bit p_v, p_c;
    int p_d;
    int seen;
    bit msat, movf;

    function automatic longint floor_div(input longint num, input longint den);
        longint q = num / den;
        if ((num % den) != 0 && num < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_clear();
        mq.delete();
        p_v = 0; p_c = 0; p_d = 0; seen = 0; msat = 0; movf = 0;
    endtask

    task automatic model_step();
        bit pop, acc;
        longint r;
        pop = (mq.size() != 0) && m_ready;
        acc = p_v && ((mq.size() < DEPTH) || pop);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(p_d);
        msat = (acc && p_c) || (msat && !clr_flags);
        movf = (p_v && !acc) || (movf && !clr_flags);
        p_v = 0;
        if (din_en) begin
            if (seen >= WARMUP && (seen - WARMUP) % DECIM == 0) begin
                r = floor_div(longint'($signed(din)) + BIAS, 64'sd1 <<< SHIFT);
                p_c = (r > 32767) || (r < -32768);
                p_d = (r > 32767) ? 32767 : (r < -32768) ? -32768 : int'(r);
                p_v = 1;
            end
            seen++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; din_en = 0; m_ready = 0; clr_flags = 0; din = '0;
        model_clear();
        @(negedge clk); @(negedge clk);
        rst = 0;
    endtask

    task automatic feed(input int d);
        din_en = 1; din = d; tick();
    endtask

    task automatic idle(input int n);
        din_en = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        model_clear();
        @(negedge clk);
        total++;
        if ({m_valid, level, m_data} !== '0) begin
            bad++; $display("FAIL reset_out: valid=%0b level=%0d data=%0d, want 0/0/0", m_valid, level, m_data);
        end
        total++;
        if ({sat_flag, ovf_flag} !== 2'b00) begin
            bad++; $display("FAIL reset_flags: sat=%0b ovf=%0b, want 0/0", sat_flag, ovf_flag);
        end
        rst = 0;
    endtask

    task automatic test_rounding();
        do_reset();
        for (int i = 0; i < WARMUP; i++) feed(0);
        feed(49152);
        for (int i = 0; i < DECIM - 1; i++) feed(0);
        feed(-49152);
        idle(2);
        total++;
        if (level !== 4'd2 || m_data !== 16'(R_POS)) begin
            bad++; $display("FAIL round_pos: level=%0d data=%0d, want 2/%0d", level, $signed(m_data), R_POS);
        end
        m_ready = 1; tick(); m_ready = 0;
        total++;
        if (level !== 4'd1 || m_data !== 16'(R_NEG)) begin
            bad++; $display("FAIL round_neg: level=%0d data=%0d, want 1/%0d", level, $signed(m_data), R_NEG);
        end
        m_ready = 1; tick(); m_ready = 0;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < WARMUP; i++) feed(0);
        feed(32'h7FFF_FFFF);
        for (int i = 0; i < DECIM - 1; i++) feed(0);
        feed(32'h8000_0000);
        idle(2);
        total++;
        if (m_data !== 16'sh7FFF || sat_flag !== 1'b1) begin
            bad++; $display("FAIL sat_pos: data=%0d sat=%0b, want 32767/1", $signed(m_data), sat_flag);
        end
        m_ready = 1; tick(); m_ready = 0;
        total++;
        if (m_data !== 16'h8000 || sat_flag !== 1'b1) begin
            bad++; $display("FAIL sat_neg: data=%0d sat=%0b, want -32768/1", $signed(m_data), sat_flag);
        end
        m_ready = 1; tick(); m_ready = 0;
        clr_flags = 1; tick(); clr_flags = 0;
        total++;
        if (sat_flag !== 1'b0) begin
            bad++; $display("FAIL sat_clr: sat=%0b, want 0", sat_flag);
        end
    endtask

    task automatic test_warmup_decim();
        int got[$];
        int first_n = -1;
        do_reset();
        m_ready = 1;
        for (int n = 0; n <= 40; n++) begin
            feed(n << 15);
            if (m_valid) begin
                got.push_back(int'($signed(m_data)));
                if (first_n < 0) first_n = n;
            end
        end
        din_en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (m_valid) got.push_back(int'($signed(m_data)));
        end
        total++;
        if (first_n !== 9) begin
            bad++; $display("FAIL first_valid: seen after n=%0d, want after n=9", first_n);
        end
        total++;
        if (got.size() !== 9) begin
            bad++; $display("FAIL decim_count: got %0d outputs, want 9", got.size());
        end
        for (int k = 0; k < got.size() && k < 9; k++) begin
            total++;
            if (got[k] !== 8 + 4 * k) begin
                bad++; $display("FAIL decim_val[%0d]: got %0d, want %0d", k, got[k], 8 + 4 * k);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int n = 0; n <= 47; n++) feed(n << 15);
        idle(2);
        total++;
        if (level !== 4'd8 || ovf_flag !== 1'b1 || sat_flag !== 1'b0) begin
            bad++; $display("FAIL ovf_full: level=%0d ovf=%0b sat=%0b, want 8/1/0", level, ovf_flag, sat_flag);
        end
        m_ready = 1;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== 16'(8 + 4 * k)) begin
                bad++; $display("FAIL ovf_drain[%0d]: valid=%0b data=%0d, want 1/%0d", k, m_valid, $signed(m_data), 8 + 4 * k);
            end
            tick();
        end
        m_ready = 0;
        total++;
        if (m_valid !== 1'b0 || level !== 4'd0) begin
            bad++; $display("FAIL ovf_empty: valid=%0b level=%0d, want 0/0", m_valid, level);
        end
    endtask

    task automatic test_full_push_pop();
        int exp_q[$] = '{12, 16, 20, 24, 28, 32, 36, 100};
        do_reset();
        for (int n = 0; n <= 39; n++) feed(n << 15);
        idle(2);
        total++;
        if (level !== 4'd8 || ovf_flag !== 1'b0) begin
            bad++; $display("FAIL fpp_fill: level=%0d ovf=%0b, want 8/0", level, ovf_flag);
        end
        feed(100 << 15);
        din_en = 0; m_ready = 1; tick(); m_ready = 0;
        total++;
        if (level !== 4'd8 || ovf_flag !== 1'b0 || m_data !== 16'd12) begin
            bad++; $display("FAIL fpp_same: level=%0d ovf=%0b data=%0d, want 8/0/12", level, ovf_flag, $signed(m_data));
        end
        m_ready = 1;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== 16'(exp_q[k])) begin
                bad++; $display("FAIL fpp_drain[%0d]: valid=%0b data=%0d, want 1/%0d", k, m_valid, $signed(m_data), exp_q[k]);
            end
            tick();
        end
        m_ready = 0;
    endtask

    task automatic test_reset_mid_run();
        int first_n = -1;
        int first_v = -1;
        do_reset();
        for (int n = 0; n <= 47; n++) feed((n == 8) ? 32'h7FFF_FFFF : (n << 15));
        idle(2);
        m_ready = 1; idle(3); m_ready = 0;
        total++;
        if (level !== 4'd5 || sat_flag !== 1'b1 || ovf_flag !== 1'b1) begin
            bad++; $display("FAIL rmr_pre: level=%0d sat=%0b ovf=%0b, want 5/1/1", level, sat_flag, ovf_flag);
        end
        rst = 1;
        model_clear();
        #1;
        total++;
        if (m_valid !== 1'b0 || level !== 4'd0 || sat_flag !== 1'b0 || ovf_flag !== 1'b0) begin
            bad++; $display("FAIL rmr_async: valid=%0b level=%0d sat=%0b ovf=%0b, want all 0", m_valid, level, sat_flag, ovf_flag);
        end
        @(negedge clk); @(negedge clk);
        rst = 0;
        m_ready = 1;
        for (int n = 0; n <= 12; n++) begin
            feed(n << 15);
            if (m_valid && first_n < 0) begin
                first_n = n;
                first_v = int'($signed(m_data));
            end
        end
        idle(2);
        m_ready = 0;
        total++;
        if (first_n !== 9 || first_v !== 8) begin
            bad++; $display("FAIL rmr_rewarm: first after n=%0d value=%0d, want n=9 value=8", first_n, first_v);
        end
    endtask

    task automatic test_random();
        int rdy_pct;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rdy_pct = (c < 1500) ? 10 : 60;
            din_en = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: din = $urandom;
                1: din = int'($urandom_range(0, 2 ** 21)) - 2 ** 20;
                2: din = (int'($urandom_range(0, 200)) - 100) * 32768 + int'($urandom_range(0, 2)) * 16384 - 1;
                default: din = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
            endcase
            m_ready   = ($urandom_range(0, 99) < rdy_pct);
            clr_flags = ($urandom_range(0, 31) == 0);
            tick();
            total++;
            if (m_valid !== (mq.size() != 0) || level !== 4'(mq.size())) begin
                bad++; $display("FAIL rnd_occ c=%0d: valid=%0b level=%0d, want %0b/%0d", c, m_valid, level, mq.size() != 0, mq.size());
            end
            total++;
            if (sat_flag !== msat || ovf_flag !== movf) begin
                bad++; $display("FAIL rnd_flags c=%0d: sat=%0b ovf=%0b, want %0b/%0b", c, sat_flag, ovf_flag, msat, movf);
            end
            if (mq.size() != 0) begin
                total++;
                if (m_data !== 16'(mq[0])) begin
                    bad++; $display("FAIL rnd_data c=%0d: got %0d, want %0d", c, $signed(m_data), mq[0]);
                end
            end
        end
        din_en = 0; m_ready = 0; clr_flags = 0;
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_warmup_decim();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
